lane_lvds_1_10: RTL

- Receive-side counterpart of the 10:1 TMDS/LVDS lane serializer.
- Accepts 2 bits per serial clock from an external DDR input primitive and reassembles 10-bit words, MSB first, matching transmit order.
- Finds the word boundary with a bit-slip search on TMDS control tokens, then monitors lock.
- Runs entirely in the serial clock domain. Word output is a 1-in-5 strobe; the pixel-domain crossing is downstream.

---
 rtl/lvds_pkg.sv | 31 +++
 rtl/lane_lvds_1_10_if.sv | 30 +++
 rtl/lane_word_align.sv | 115 +++++++++++
 rtl/lane_lvds_1_10.sv | 80 ++++++++
 4 files changed

// File: rtl/lvds_pkg.sv
//==============================================================================
// Module : lvds_pkg
// Brief  : Shared constants and types for the 1:10 LVDS/TMDS receive lane.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package lvds_pkg;

    localparam int unsigned C_WORD_W = 10;

    localparam logic [C_WORD_W-1:0] C_TOKEN_0 = 10'b1101010100;
    localparam logic [C_WORD_W-1:0] C_TOKEN_1 = 10'b0010101011;
    localparam logic [C_WORD_W-1:0] C_TOKEN_2 = 10'b0101010100;
    localparam logic [C_WORD_W-1:0] C_TOKEN_3 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_SLIP    = 2'd2,
        ST_LOCKED  = 2'd3
    } align_state_t;

    function automatic logic is_token(input logic [C_WORD_W-1:0] word);
        return (word == C_TOKEN_0) || (word == C_TOKEN_1) ||
               (word == C_TOKEN_2) || (word == C_TOKEN_3);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lane_lvds_1_10_if.sv
//==============================================================================
// Module : lane_lvds_1_10_if
// Brief  : DDR bit input and recovered-word output bundle of the receive lane.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface lane_lvds_1_10_if;

    logic [1:0] I_ddr_data;
    logic [9:0] O_data;
    logic       O_data_valid;
    logic       O_token;
    logic       O_locked;
    logic [3:0] O_bit_offset;

    // master: the lane itself; slave: the DDR source / word consumer side
    modport master (
        input  I_ddr_data,
        output O_data, O_data_valid, O_token, O_locked, O_bit_offset
    );

    modport slave (
        output I_ddr_data,
        input  O_data, O_data_valid, O_token, O_locked, O_bit_offset
    );

endinterface

`default_nettype wire

// File: rtl/lane_word_align.sv
//==============================================================================
// Module : lane_word_align
// Brief  : Word-boundary search FSM: bit-slip on token absence, lock tracking.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lane_word_align #(
    parameter int unsigned P_LOCK_CNT     = 16,
    parameter int unsigned P_SEARCH_WORDS = 4096,
    parameter int unsigned P_UNLOCK_WORDS = 8192
) (
    input  wire logic       I_serial_clk,
    input  wire logic       I_rst_n,
    input  wire logic       I_word_stb,
    input  wire logic       I_token,
    output logic      [3:0] O_offset,
    output logic            O_locked
);
    import lvds_pkg::*;

    localparam int unsigned C_SW = $clog2(P_SEARCH_WORDS + 1);
    localparam int unsigned C_MW = $clog2(P_LOCK_CNT + 1);
    localparam int unsigned C_UW = $clog2(P_UNLOCK_WORDS + 1);
    localparam logic [3:0]  C_OFF_MAX = 4'd9;

    align_state_t    r_state, w_state_nxt;
    logic [C_SW-1:0] r_search_cnt, w_search_nxt, w_search_inc;
    logic [C_MW-1:0] r_match_cnt, w_match_nxt, w_match_inc;
    logic [C_UW-1:0] r_unlock_cnt, w_unlock_nxt, w_unlock_inc;
    logic [3:0]      r_offset, w_offset_nxt;

    assign w_search_inc = r_search_cnt + 1'b1;
    assign w_match_inc  = r_match_cnt + 1'b1;
    assign w_unlock_inc = r_unlock_cnt + 1'b1;

    always_ff @(posedge I_serial_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state      <= ST_SEARCH;
            r_search_cnt <= '0;
            r_match_cnt  <= '0;
            r_unlock_cnt <= '0;
            r_offset     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_search_cnt <= w_search_nxt;
            r_match_cnt  <= w_match_nxt;
            r_unlock_cnt <= w_unlock_nxt;
            r_offset     <= w_offset_nxt;
        end
    end

    // One decision per captured word; all transitions fire on the exact count.
    always_comb begin
        w_state_nxt  = r_state;
        w_search_nxt = r_search_cnt;
        w_match_nxt  = r_match_cnt;
        w_unlock_nxt = r_unlock_cnt;
        w_offset_nxt = r_offset;
        if (I_word_stb) begin
            unique case (r_state)
                ST_SEARCH: begin
                    if (I_token) begin
                        w_state_nxt = ST_CONFIRM;
                        w_match_nxt = C_MW'(1);
                    end else if (w_search_inc == C_SW'(P_SEARCH_WORDS)) begin
                        w_state_nxt  = ST_SLIP;
                        w_search_nxt = '0;
                    end else begin
                        w_search_nxt = w_search_inc;
                    end
                end
                ST_CONFIRM: begin
                    if (!I_token) begin
                        w_state_nxt  = ST_SEARCH;
                        w_match_nxt  = '0;
                        w_search_nxt = '0;
                    end else if (w_match_inc == C_MW'(P_LOCK_CNT)) begin
                        w_state_nxt = ST_LOCKED;
                        w_match_nxt = '0;
                    end else begin
                        w_match_nxt = w_match_inc;
                    end
                end
                ST_SLIP: begin
                    // The word seen here straddles the old boundary and is ignored.
                    w_offset_nxt = (r_offset == C_OFF_MAX) ? 4'd0 : r_offset + 4'd1;
                    w_state_nxt  = ST_SEARCH;
                    w_search_nxt = '0;
                end
                ST_LOCKED: begin
                    if (I_token) begin
                        w_unlock_nxt = '0;
                    end else if (w_unlock_inc == C_UW'(P_UNLOCK_WORDS)) begin
                        w_state_nxt  = ST_SEARCH;
                        w_unlock_nxt = '0;
                        w_search_nxt = '0;
                        w_match_nxt  = '0;
                    end else begin
                        w_unlock_nxt = w_unlock_inc;
                    end
                end
                default: w_state_nxt = ST_SEARCH;
            endcase
        end
    end

    always_comb begin
        O_offset = r_offset;
        O_locked = (r_state == ST_LOCKED);
    end

endmodule

`default_nettype wire

// File: rtl/lane_lvds_1_10.sv
//==============================================================================
// Module : lane_lvds_1_10
// Brief  : 1:10 DDR deserializer lane with token-based word alignment.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lane_lvds_1_10 #(
    parameter int unsigned P_LOCK_CNT     = 16,
    parameter int unsigned P_SEARCH_WORDS = 4096,
    parameter int unsigned P_UNLOCK_WORDS = 8192
) (
    input  wire logic         I_serial_clk,
    input  wire logic         I_rst_n,
    lane_lvds_1_10_if.master  bus
);
    import lvds_pkg::*;

    localparam logic [2:0] C_PHASE_LAST = 3'd4;

    logic [2*C_WORD_W-1:0] r_hist;
    logic [2*C_WORD_W-1:0] w_hist_shr;
    logic [2:0]            r_phase;
    logic [C_WORD_W-1:0]   r_data;
    logic                  r_valid;
    logic                  r_token;
    logic [C_WORD_W-1:0]   w_window;
    logic                  w_token;
    logic                  w_word_stb;
    logic [3:0]            w_offset;
    logic                  w_locked;
    logic                  w_hist_unused;

    assign w_word_stb    = (r_phase == C_PHASE_LAST);
    assign w_hist_shr    = r_hist >> w_offset;
    assign w_window      = w_hist_shr[C_WORD_W-1:0];
    assign w_hist_unused = ^w_hist_shr[2*C_WORD_W-1:C_WORD_W];
    assign w_token       = is_token(w_window);

    // hist[0] is the newest bit; the rising-edge sample is older than the falling one.
    always_ff @(posedge I_serial_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_hist  <= '0;
            r_phase <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_token <= 1'b0;
        end else begin
            r_hist  <= {r_hist[2*C_WORD_W-3:0], bus.I_ddr_data[1], bus.I_ddr_data[0]};
            r_phase <= (r_phase == C_PHASE_LAST) ? 3'd0 : r_phase + 3'd1;
            r_valid <= w_word_stb;
            if (w_word_stb) begin
                r_data  <= w_window;
                r_token <= w_token;
            end
        end
    end

    lane_word_align #(
        .P_LOCK_CNT     (P_LOCK_CNT),
        .P_SEARCH_WORDS (P_SEARCH_WORDS),
        .P_UNLOCK_WORDS (P_UNLOCK_WORDS)
    ) u_align (
        .I_serial_clk (I_serial_clk),
        .I_rst_n      (I_rst_n),
        .I_word_stb   (w_word_stb),
        .I_token      (w_token),
        .O_offset     (w_offset),
        .O_locked     (w_locked)
    );

    assign bus.O_data       = r_data;
    assign bus.O_data_valid = r_valid;
    assign bus.O_token      = r_token;
    assign bus.O_locked     = w_locked;
    assign bus.O_bit_offset = w_offset;

endmodule

`default_nettype wire
